lieat_general_bwe_sram: RTL and testbench

Parametrised 1R1W register-file SRAM built from flops. It generalises the fixed 64x64 array: width and depth are configurable, writes carry a per-lane write-enable mask, and reads have a registered output. A post-reset init sequencer clears every entry. Used for pipeline-side tables and buffers in the core (BTB, small caches, queue storage).

---
 rtl/lieat_sram_pkg.sv | 32 +++
 rtl/lieat_general_dfflr.sv | 21 ++
 rtl/lieat_general_sram_init.sv | 53 +++++
 rtl/lieat_general_bwe_sram.sv | 100 ++++++++++
 tb/tb_lieat_general_bwe_sram.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lieat_sram_pkg.sv
// Shared types and helpers for the lieat general byte-write-enable SRAM.
// merge() works on fixed maximum widths; callers zero-extend inputs and truncate the result.
package lieat_sram_pkg;

  typedef enum logic {
    SRAM_INIT = 1'b0,
    SRAM_RUN  = 1'b1
  } sram_state_e;

  localparam int MERGE_W  = 1024;
  localparam int MERGE_NB = 1024;

  // Bit i belongs to lane i/bw; lanes whose enable is set take new_v, the rest keep old_v.
  function automatic logic [MERGE_W-1:0] merge(
    input logic [MERGE_W-1:0]  old_v,
    input logic [MERGE_W-1:0]  new_v,
    input logic [MERGE_NB-1:0] be,
    input int unsigned         bw
  );
    logic [MERGE_W-1:0]  res;
    logic [MERGE_NB-1:0] lane_sel;
    res = old_v;
    for (int unsigned i = 0; i < MERGE_W; i++) begin
      lane_sel = be >> (i / bw);
      if (lane_sel[0]) begin
        res[i] = new_v[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lieat_general_dfflr.sv
// Load-enabled data flop without reset; one instance per storage entry.
module lieat_general_dfflr #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         lden_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clock) begin
    if (lden_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/lieat_general_sram_init.sv
// Post-reset clear sequencer: walks every entry once in INIT, then parks in RUN.
module lieat_general_sram_init
  import lieat_sram_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  output logic          init_we,
  output logic [AW-1:0] init_addr,
  output logic          init_done
);

  sram_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= SRAM_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_we   = 1'b0;
    init_addr = cnt_q;
    init_done = 1'b0;
    case (state_q)
      SRAM_INIT: begin
        init_we = 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = SRAM_RUN;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      SRAM_RUN: begin
        init_done = 1'b1;
      end
      default: begin
        state_d = SRAM_INIT;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/lieat_general_bwe_sram.sv
// Parametrised 1R1W flop-based SRAM with per-lane write enables, registered read and init clear.
// Define LIEAT_SRAM_WR_BYPASS_EN for write-first same-address collisions (default is read-first).
module lieat_general_bwe_sram
  import lieat_sram_pkg::*;
#(
  parameter int            DW       = 64,
  parameter int            DEPTH    = 64,
  parameter int            AW       = $clog2(DEPTH),
  parameter int            BW       = 8,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wen,
  input  logic [AW-1:0]      waddr,
  input  logic [DW-1:0]      wdata,
  input  logic [DW/BW-1:0]   wbe,
  input  logic               ren,
  input  logic [AW-1:0]      raddr,
  output logic [DW-1:0]      rdata,
  output logic               rvld,
  output logic               init_done
);

  localparam int NB = DW / BW;

  logic          init_we;
  logic [AW-1:0] init_addr;
  logic          init_done_w;

  lieat_general_sram_init #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_init (
    .clock     (clock),
    .reset     (reset),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done_w)
  );

  logic [DW-1:0] mem_q [DEPTH];
  logic          wr_ok, wr_en;
  logic [DW-1:0] wr_old, wr_merged, entry_d;

  always_comb begin
    wr_ok     = 32'(waddr) < DEPTH;
    wr_en     = init_done_w && wen && wr_ok;
    wr_old    = wr_ok ? mem_q[waddr] : '0;
    wr_merged = DW'(merge(MERGE_W'(wr_old), MERGE_W'(wdata), MERGE_NB'(wbe), BW));
    entry_d   = init_we ? INIT_VAL : wr_merged;
  end

  // Init and user writes never overlap: user writes need init_done, init writes need INIT.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic entry_en;
    assign entry_en = (init_we && (init_addr == AW'(gi))) || (wr_en && (waddr == AW'(gi)));
    lieat_general_dfflr #(
      .W (DW)
    ) u_entry (
      .clock  (clock),
      .lden_i (entry_en),
      .d_i    (entry_d),
      .q_o    (mem_q[gi])
    );
  end

  logic          rd_en, rd_ok;
  logic [DW-1:0] rd_old, rd_val;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvld_q, rvld_d;

  always_comb begin
    rd_en  = init_done_w && ren;
    rd_ok  = 32'(raddr) < DEPTH;
    rd_old = rd_ok ? mem_q[raddr] : '0;
`ifdef LIEAT_SRAM_WR_BYPASS_EN
    rd_val = (wr_en && (waddr == raddr)) ? wr_merged : rd_old;
`else
    rd_val = rd_old;
`endif
    rdata_d = rd_en ? rd_val : rdata_q;
    rvld_d  = rd_en;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
    end
  end

  assign rdata     = rdata_q;
  assign rvld      = rvld_q;
  assign init_done = init_done_w;

endmodule

// File: tb/tb_lieat_general_bwe_sram.sv
// Bench for lieat_general_bwe_sram: a 64-deep and a 48-deep instance share one stimulus stream.
module tb_lieat_general_bwe_sram;

  localparam int D0 = 64;
  localparam int D1 = 48;
`ifdef LIEAT_SRAM_WR_BYPASS_EN
  localparam logic [63:0] COLL_EXP = 64'h5A;
`else
  localparam logic [63:0] COLL_EXP = 64'hA5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, wen, ren;
  logic [5:0]  waddr, raddr;
  logic [63:0] wdata;
  logic [7:0]  wbe;
  logic [63:0] rdata_a, rdata_b;
  logic        rvld_a, rvld_b, done_a, done_b;

  lieat_general_bwe_sram #(.DW(64), .DEPTH(D0), .BW(8)) dut64 (
    .clock(clk), .reset(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvld(rvld_a), .init_done(done_a)
  );

  lieat_general_bwe_sram #(.DW(64), .DEPTH(D1), .BW(8)) dut48 (
    .clock(clk), .reset(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvld(rvld_b), .init_done(done_b)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: contents, cycles since reset release, expected read port.
  logic [63:0] mmem [2][64];
  int          mcyc [2];
  logic [63:0] mrd  [2];
  logic        mrv  [2];

  typedef struct {
    logic        wen;
    logic [5:0]  waddr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic        ren;
    logic [5:0]  raddr;
    logic [63:0] exp_rdata;
    logic        exp_rvld;
  } vec_t;
  vec_t tv [16];

  function automatic int depth_of(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic logic [63:0] lane_merge(input logic [63:0] o, input logic [63:0] n,
                                             input logic [7:0] be);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mcyc[k] = 0;
        mrd[k]  = 64'h0;
        mrv[k]  = 1'b0;
        for (int e = 0; e < 64; e++) mmem[k][e] = 64'h0;
      end else begin
        if (mcyc[k] >= depth_of(k)) begin
          if (ren) begin
            mrv[k] = 1'b1;
            if (int'(raddr) < depth_of(k)) begin
              mrd[k] = mmem[k][raddr];
`ifdef LIEAT_SRAM_WR_BYPASS_EN
              if (wen && waddr == raddr) mrd[k] = lane_merge(mrd[k], wdata, wbe);
`endif
            end else begin
              mrd[k] = 64'h0;
            end
          end else begin
            mrv[k] = 1'b0;
          end
          if (wen && int'(waddr) < depth_of(k))
            mmem[k][waddr] = lane_merge(mmem[k][waddr], wdata, wbe);
        end
        if (mcyc[k] < 1000000) mcyc[k]++;
      end
    end
  endtask

  task automatic model_check();
    chk("model64_rdata", rdata_a, mrd[0]);
    chk("model64_rvld", 64'(rvld_a), 64'(mrv[0]));
    chk("model64_init_done", 64'(done_a), 64'(mcyc[0] >= D0));
    chk("model48_rdata", rdata_b, mrd[1]);
    chk("model48_rvld", 64'(rvld_b), 64'(mrv[1]));
    chk("model48_init_done", 64'(done_b), 64'(mcyc[1] >= D1));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic idle();
    wen = 1'b0; ren = 1'b0; waddr = '0; raddr = '0; wdata = '0; wbe = '0;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [63:0] d, input logic [7:0] be);
    wen = 1'b1; ren = 1'b0; waddr = a; wdata = d; wbe = be;
  endtask

  task automatic do_read(input logic [5:0] a);
    wen = 1'b0; ren = 1'b1; raddr = a;
  endtask

  initial begin
    tv[0]  = '{1'b1, 6'd5,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, 6'd0,  64'h0, 1'b0};
    tv[1]  = '{1'b1, 6'd5,  64'h1122_3344_5566_7788, 8'h0F, 1'b0, 6'd0,  64'h0, 1'b0};
    tv[2]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd5,  64'hFFFF_FFFF_5566_7788, 1'b1};
    tv[3]  = '{1'b1, 6'd9,  64'hA5, 8'hFF, 1'b0, 6'd0,  64'hFFFF_FFFF_5566_7788, 1'b0};
    tv[4]  = '{1'b1, 6'd9,  64'h5A, 8'hFF, 1'b1, 6'd9,  COLL_EXP, 1'b1};
    tv[5]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd9,  64'h5A, 1'b1};
    tv[6]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b0, 6'd0,  64'h5A, 1'b0};
    tv[7]  = '{1'b1, 6'd12, 64'h0123_4567_89AB_CDEF, 8'hA5, 1'b0, 6'd0, 64'h5A, 1'b0};
    tv[8]  = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd12, 64'h0100_4500_00AB_00EF, 1'b1};
    tv[9]  = '{1'b1, 6'd5,  64'h0, 8'h00, 1'b0, 6'd0,  64'h0100_4500_00AB_00EF, 1'b0};
    tv[10] = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd5,  64'hFFFF_FFFF_5566_7788, 1'b1};
    tv[11] = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd63, 64'h0, 1'b1};
    tv[12] = '{1'b1, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 1'b0, 6'd0, 64'h0, 1'b0};
    tv[13] = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd63, 64'hFF00_0000_0000_0000, 1'b1};
    tv[14] = '{1'b1, 6'd12, 64'hCAFE, 8'hFF, 1'b1, 6'd5, 64'hFFFF_FFFF_5566_7788, 1'b1};
    tv[15] = '{1'b0, 6'd0,  64'h0, 8'h00, 1'b1, 6'd12, 64'h0000_0000_0000_CAFE, 1'b1};

    // Reset state
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    chk("reset_rdata", rdata_a, 64'h0);
    chk("reset_rvld", 64'(rvld_a), 64'h0);
    chk("reset_init_done", 64'(done_a), 64'h0);

    // Init timing, with requests injected at cycle 10 of INIT
    rst_n = 1'b1;
    for (int c = 1; c <= 65; c++) begin
      if (c == 11) begin
        do_write(6'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        ren = 1'b1; raddr = 6'd3;
      end else begin
        idle();
      end
      tick();
      chk("init_done64_timing", 64'(done_a), 64'(c >= 64));
      chk("init_done48_timing", 64'(done_b), 64'(c >= 48));
      chk("init_rvld64_quiet", 64'(rvld_a), 64'h0);
    end
    $display("init: init_done64=%0b init_done48=%0b after 65 cycles", done_a, done_b);

    // Every entry reads back cleared
    for (int a = 0; a < 64; a++) begin
      do_read(6'(a));
      tick();
      chk("init_clear_rdata", rdata_a, 64'h0);
      chk("init_clear_rvld", 64'(rvld_a), 64'h1);
    end

    // Table: lane masks, collision, wbe=0, boundary address, independent read/write
    for (int i = 0; i < 16; i++) begin
      wen = tv[i].wen; waddr = tv[i].waddr; wdata = tv[i].wdata; wbe = tv[i].wbe;
      ren = tv[i].ren; raddr = tv[i].raddr;
      tick();
      $display("vec %0d: wen=%0b wa=%0d wbe=%h ren=%0b ra=%0d -> rdata=%h rvld=%0b",
               i, tv[i].wen, tv[i].waddr, tv[i].wbe, tv[i].ren, tv[i].raddr, rdata_a, rvld_a);
      chk($sformatf("vec%0d_rdata", i), rdata_a, tv[i].exp_rdata);
      chk($sformatf("vec%0d_rvld", i), 64'(rvld_a), 64'(tv[i].exp_rvld));
    end

    // Mid-operation reset
    do_write(6'd7, 64'hDEAD, 8'hFF);
    tick();
    do_read(6'd7);
    tick();
    chk("prereset_rdata", rdata_a, 64'hDEAD);
    rst_n = 1'b0;
    idle();
    tick();
    chk("midreset_rdata", rdata_a, 64'h0);
    chk("midreset_rvld", 64'(rvld_a), 64'h0);
    chk("midreset_init_done", 64'(done_a), 64'h0);
    rst_n = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      chk("reinit_done64", 64'(done_a), 64'(c >= 64));
    end
    do_read(6'd7);
    tick();
    chk("reinit_addr7_rdata", rdata_a, 64'h0);
    chk("reinit_addr7_rvld", 64'(rvld_a), 64'h1);
    $display("midreset: addr7 after reinit rdata=%h", rdata_a);

    // Non-power-of-2 depth: out-of-range write dropped, out-of-range read returns 0
    do_write(6'd50, 64'h1, 8'hFF);
    tick();
    do_write(6'd47, 64'h1, 8'hFF);
    tick();
    do_read(6'd47);
    tick();
    chk("d48_addr47_rdata", rdata_b, 64'h1);
    chk("d48_addr47_rvld", 64'(rvld_b), 64'h1);
    do_read(6'd50);
    tick();
    chk("d48_addr50_rdata", rdata_b, 64'h0);
    chk("d48_addr50_rvld", 64'(rvld_b), 64'h1);
    $display("depth48: addr50 rdata=%h rvld=%0b", rdata_b, rvld_b);

    // Randomised traffic against the model, with occasional resets
    for (int n = 0; n < 1200; n++) begin
      rst_n = ($urandom_range(0, 399) != 0);
      wen   = ($urandom_range(0, 1) == 1);
      waddr = 6'($urandom_range(0, 63));
      wdata = {$urandom(), $urandom()};
      wbe   = 8'($urandom());
      ren   = ($urandom_range(0, 9) < 6);
      raddr = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom_range(0, 63));
      tick();
    end
    rst_n = 1'b1;
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
